// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: segment patterns {g,f,e,d,c,b,a}, BCD limit, digit enables.
package bcd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_MAX  = 4'd9;

    localparam logic [1:0] AN_UNITS = 2'b01;
    localparam logic [1:0] AN_TENS  = 2'b10;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, zero latency, no flow control.
// Codes 10-15 decode to an all-off pattern.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit decade cascade with multiplexed 7-segment output; Seg lags the digit registers by one Clk, no backpressure.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit while its enable is active.
module bcd_display_scanner
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Q8,
    input  logic       Q4,
    input  logic       Q2,
    input  logic       Q1,
    output logic [6:0] Seg,
    output logic [1:0] An,
    output logic [3:0] Tens,
    output logic       Err
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       din;
    logic             legal;
    logic [3:0]       units_r;
    logic [3:0]       prev_r;
    logic             wrap;
    logic [CNT_W-1:0] scan_cnt;
    logic             sel;
    logic             sel_n;
    logic [3:0]       disp_digit;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_nxt;

    assign din   = {Q8, Q4, Q2, Q1};
    assign legal = (din <= BCD_MAX);
    // An illegal sample leaves units_r at 9, so a 9,bad,0 run still counts as a wrap.
    assign wrap  = (prev_r == BCD_MAX) && (units_r == 4'd0);

    assign sel_n      = (scan_cnt == CNT_LAST) ? ~sel : sel;
    assign disp_digit = sel_n ? Tens : units_r;

    bcd_to_seg7 u_dec (
        .bcd (disp_digit),
        .seg (seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign seg_nxt = (sel_n && (Tens == 4'd0)) ? SEG_BLANK : seg_dec;
`else
    assign seg_nxt = seg_dec;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            units_r  <= 4'd0;
            prev_r   <= 4'd0;
            Tens     <= 4'd0;
            Err      <= 1'b0;
            scan_cnt <= '0;
            sel      <= 1'b0;
            An       <= AN_UNITS;
            Seg      <= SEG_0;
        end else begin
            if (legal) begin
                units_r <= din;
            end else begin
                Err <= 1'b1;
            end
            prev_r <= units_r;

            if (wrap) begin
                Tens <= (Tens == BCD_MAX) ? 4'd0 : Tens + 4'd1;
            end

            scan_cnt <= (scan_cnt == CNT_LAST) ? '0 : scan_cnt + CNT_W'(1);
            // Enable and segments move together so a digit never shows the other's pattern.
            sel <= sel_n;
            An  <= sel_n ? AN_TENS : AN_UNITS;
            Seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed table-driven bench for bcd_display_scanner (SCAN_DIV=4), plus hand sequences for cascade and reset.
module tb_bcd_display_scanner;

    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P6 = 7'b1111101;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1101111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZT = 7'b0000000;
`else
    localparam logic [6:0] ZT = 7'b0111111;
`endif

    typedef struct {
        logic [3:0] din;
        logic [3:0] tens;
        logic       err;
        logic [1:0] an;
        logic [6:0] seg;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Q8 = 1'b0, Q4 = 1'b0, Q2 = 1'b0, Q1 = 1'b0;
    logic [6:0] Seg;
    logic [1:0] An;
    logic [3:0] Tens;
    logic       Err;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t tbl[28];

    bcd_display_scanner #(.SCAN_DIV(4)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Q8   (Q8),
        .Q4   (Q4),
        .Q2   (Q2),
        .Q1   (Q1),
        .Seg  (Seg),
        .An   (An),
        .Tens (Tens),
        .Err  (Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {Q8, Q4, Q2, Q1} = v;
    endtask

    // One edge, then sample one time unit later.
    task automatic step(input logic [3:0] v);
        drive(v);
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] t, input logic e,
                             input logic [1:0] a, input logic [6:0] s);
        check({tag, ".tens"}, {4'd0, Tens}, {4'd0, t});
        check({tag, ".err"},  {7'd0, Err},  {7'd0, e});
        check({tag, ".an"},   {6'd0, An},   {6'd0, a});
        check({tag, ".seg"},  {1'b0, Seg},  {1'b0, s});
    endtask

    initial begin
        // Count 0..9,0 past the wrap: tens bumps two edges after the 0 is driven.
        tbl[0]  = '{4'd0, 4'd0, 1'b0, 2'b01, P0};
        tbl[1]  = '{4'd1, 4'd0, 1'b0, 2'b01, P0};
        tbl[2]  = '{4'd2, 4'd0, 1'b0, 2'b01, P1};
        tbl[3]  = '{4'd3, 4'd0, 1'b0, 2'b10, ZT};
        tbl[4]  = '{4'd4, 4'd0, 1'b0, 2'b10, ZT};
        tbl[5]  = '{4'd5, 4'd0, 1'b0, 2'b10, ZT};
        tbl[6]  = '{4'd6, 4'd0, 1'b0, 2'b10, ZT};
        tbl[7]  = '{4'd7, 4'd0, 1'b0, 2'b01, P6};
        tbl[8]  = '{4'd8, 4'd0, 1'b0, 2'b01, P7};
        tbl[9]  = '{4'd9, 4'd0, 1'b0, 2'b01, P8};
        tbl[10] = '{4'd0, 4'd0, 1'b0, 2'b01, P9};
        tbl[11] = '{4'd0, 4'd1, 1'b0, 2'b10, ZT};
        tbl[12] = '{4'd0, 4'd1, 1'b0, 2'b10, P1};
        // Units 7 / tens 1 held: enable flips every 4 edges.
        tbl[13] = '{4'd7, 4'd1, 1'b0, 2'b10, P1};
        tbl[14] = '{4'd7, 4'd1, 1'b0, 2'b10, P1};
        tbl[15] = '{4'd7, 4'd1, 1'b0, 2'b01, P7};
        tbl[16] = '{4'd7, 4'd1, 1'b0, 2'b01, P7};
        tbl[17] = '{4'd7, 4'd1, 1'b0, 2'b01, P7};
        tbl[18] = '{4'd7, 4'd1, 1'b0, 2'b01, P7};
        tbl[19] = '{4'd7, 4'd1, 1'b0, 2'b10, P1};
        tbl[20] = '{4'd7, 4'd1, 1'b0, 2'b10, P1};
        tbl[21] = '{4'd7, 4'd1, 1'b0, 2'b10, P1};
        tbl[22] = '{4'd7, 4'd1, 1'b0, 2'b10, P1};
        // 9, illegal 12, 0: units holds 9, err sticks, one wrap.
        tbl[23] = '{4'd9,  4'd1, 1'b0, 2'b01, P7};
        tbl[24] = '{4'd12, 4'd1, 1'b1, 2'b01, P9};
        tbl[25] = '{4'd0,  4'd1, 1'b1, 2'b01, P9};
        tbl[26] = '{4'd0,  4'd2, 1'b1, 2'b01, P0};
        tbl[27] = '{4'd0,  4'd2, 1'b1, 2'b10, P2};

        // Reset held for two edges, illegal input present to show reset dominates Err.
        Rst = 1'b1;
        drive(4'd12);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        drive(4'd0);
        check_all("reset", 4'd0, 1'b0, 2'b01, P0);

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].din);
            check_all($sformatf("vec%0d", i), tbl[i].tens, tbl[i].err, tbl[i].an, tbl[i].seg);
        end

        // 100 full decades from reset: tens follows the wrap count modulo 10.
        Rst = 1'b1;
        step(4'd0);
        Rst = 1'b0;
        for (int j = 0; j < 1002; j++) begin
            step(4'(j % 10));
            if (j % 10 == 1)
                check($sformatf("cascade%0d", j), {4'd0, Tens}, 8'((j / 10) % 10));
        end
        check("cascade.err", {7'd0, Err}, 8'd0);

        // Build tens=5 with err set, then reset mid-scan.
        Rst = 1'b1;
        step(4'd0);
        Rst = 1'b0;
        for (int j = 0; j < 52; j++) step(4'(j % 10));
        step(4'd13);
        step(4'd1);
        check("pre_rst.tens", {4'd0, Tens}, 8'd5);
        check("pre_rst.err",  {7'd0, Err},  8'd1);
        Rst = 1'b1;
        step(4'd15);
        Rst = 1'b0;
        check_all("mid_rst", 4'd0, 1'b0, 2'b01, P0);
        step(4'd3);
        step(4'd3);
        check_all("post_rst", 4'd0, 1'b0, 2'b01, P3);

        // Held 9s must not wrap.
        for (int j = 0; j < 6; j++) step(4'd9);
        check("hold9.tens", {4'd0, Tens}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
